// File: rtl/reverb_debug_cmd_decoder.sv
// System-clock-side JTAG debug command decoder: synchronises the update
// strobes, captures IR/DR, and queues commands in a first-word fall-through
// FIFO with overflow reporting.
module reverb_debug_cmd_decoder #(
    parameter int unsigned SR_WIDTH    = 38,
    parameter int unsigned IR_WIDTH    = 2,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DEPTH       = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [IR_WIDTH-1:0]        ir_in_i,
    input  logic [SR_WIDTH-1:0]        sr_i,
    input  logic                       vs_uir_i,
    input  logic                       vs_udr_i,
    output logic [SR_WIDTH-1:0]        jdo_o,
    output logic                       act_valid_o,
    input  logic                       act_ready_i,
    output logic [IR_WIDTH-1:0]        act_ir_o,
    output logic [SR_WIDTH-1:0]        act_data_o,
    output logic [$clog2(DEPTH):0]     level_o,
    output logic                       overflow_o,
    output logic [7:0]                 drop_count_o,
    input  logic                       clear_ovf_i
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned EW = IR_WIDTH + SR_WIDTH;

    logic [SYNC_STAGES-1:0] uir_sync_q;
    logic [SYNC_STAGES-1:0] udr_sync_q;
    logic                   uir_hist_q;
    logic                   udr_hist_q;
    logic                   uir_edge;
    logic                   udr_edge;

    logic [IR_WIDTH-1:0]    ir_q;
    logic [SR_WIDTH-1:0]    jdo_q;
    logic [EW-1:0]          mem_q [DEPTH];
    logic [AW:0]            wr_ptr_q, wr_ptr_d;
    logic [AW:0]            rd_ptr_q, rd_ptr_d;
    logic                   overflow_q, overflow_d;
    logic [7:0]             drop_count_q, drop_count_d;

    logic [LW-1:0]          level;
    logic                   full;
    logic                   empty;
    logic                   pop;
    logic                   push_ok;
    logic                   drop;
    logic [IR_WIDTH-1:0]    ir_eff;
    logic [EW-1:0]          head;

    // Strobe synchronisers; reset to ones so a held strobe never looks like a new edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            uir_sync_q <= '1;
            udr_sync_q <= '1;
            uir_hist_q <= 1'b1;
            udr_hist_q <= 1'b1;
        end else begin
            uir_sync_q <= {uir_sync_q[SYNC_STAGES-2:0], vs_uir_i};
            udr_sync_q <= {udr_sync_q[SYNC_STAGES-2:0], vs_udr_i};
            uir_hist_q <= uir_sync_q[SYNC_STAGES-1];
            udr_hist_q <= udr_sync_q[SYNC_STAGES-1];
        end
    end

    assign uir_edge = uir_sync_q[SYNC_STAGES-1] & ~uir_hist_q;
    assign udr_edge = udr_sync_q[SYNC_STAGES-1] & ~udr_hist_q;

    // FIFO status and push/pop/drop decisions.
    always_comb begin
        level   = LW'(wr_ptr_q - rd_ptr_q);
        full    = (level == LW'(DEPTH));
        empty   = (level == '0);
        pop     = ~empty & act_ready_i;
        push_ok = udr_edge & (~full | pop);
        drop    = udr_edge & full & ~pop;
        ir_eff  = uir_edge ? ir_in_i : ir_q;
        head    = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    end

    // Next-state for pointers and overflow bookkeeping; a drop beats a clear.
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        overflow_d   = overflow_q;
        drop_count_d = drop_count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        if (pop)     rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        if (drop) begin
            overflow_d = 1'b1;
            if (clear_ovf_i)                drop_count_d = 8'd1;
            else if (drop_count_q != 8'hFF) drop_count_d = drop_count_q + 8'd1;
        end else if (clear_ovf_i) begin
            overflow_d   = 1'b0;
            drop_count_d = 8'd0;
        end
    end

    // Control registers: IR capture, jdo capture, pointers, overflow state.
    always_ff @(posedge clk) begin
        if (reset) begin
            ir_q         <= '0;
            jdo_q        <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            overflow_q   <= 1'b0;
            drop_count_q <= 8'd0;
        end else begin
            if (uir_edge) ir_q  <= ir_in_i;
            if (udr_edge) jdo_q <= sr_i;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            overflow_q   <= overflow_d;
            drop_count_q <= drop_count_d;
        end
    end

    // Command storage; not reset, the head is masked while empty.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= {ir_eff, sr_i};
    end

    assign jdo_o        = jdo_q;
    assign act_valid_o  = ~empty;
    assign act_ir_o     = head[EW-1:SR_WIDTH];
    assign act_data_o   = head[SR_WIDTH-1:0];
    assign level_o      = level;
    assign overflow_o   = overflow_q;
    assign drop_count_o = drop_count_q;

endmodule

// File: tb/tb_reverb_debug_cmd_decoder.sv
// Bench for reverb_debug_cmd_decoder: directed scenarios plus random traffic,
// compared every cycle against a queue-based model of the command stream.
module tb_reverb_debug_cmd_decoder;

    localparam int unsigned SRW   = 38;
    localparam int unsigned IRW   = 2;
    localparam int unsigned S     = 2;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned LW    = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [IRW-1:0]   ir_in = '0;
    logic [SRW-1:0]   sr = '0;
    logic             vs_uir = 1'b0;
    logic             vs_udr = 1'b0;
    logic [SRW-1:0]   jdo;
    logic             act_valid;
    logic             act_ready = 1'b0;
    logic [IRW-1:0]   act_ir;
    logic [SRW-1:0]   act_data;
    logic [LW-1:0]    level;
    logic             overflow;
    logic [7:0]       drop_count;
    logic             clear_ovf = 1'b0;

    int checks = 0;
    int errors = 0;

    reverb_debug_cmd_decoder #(
        .SR_WIDTH(SRW), .IR_WIDTH(IRW), .SYNC_STAGES(S), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .ir_in_i(ir_in), .sr_i(sr),
        .vs_uir_i(vs_uir), .vs_udr_i(vs_udr), .jdo_o(jdo),
        .act_valid_o(act_valid), .act_ready_i(act_ready),
        .act_ir_o(act_ir), .act_data_o(act_data), .level_o(level),
        .overflow_o(overflow), .drop_count_o(drop_count), .clear_ovf_i(clear_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A strobe level sampled at clk edge n becomes a command at edge n+S if
    // it was a 0->1 change versus the previous sample; reset makes every
    // remembered sample look high.
    logic [IRW+SRW-1:0] mq[$];
    bit               m_init = 0;
    bit               m_ovf;
    int               m_drops;
    logic [SRW-1:0]   m_jdo;
    logic [IRW-1:0]   m_irq;
    bit               udr_s[$];
    bit               uir_s[$];

    always @(posedge clk) begin
        bit ue, de, pop, full;
        logic [IRW-1:0] ire;
        if (reset) begin
            mq.delete();
            m_ovf = 0; m_drops = 0; m_jdo = '0; m_irq = '0;
            udr_s.delete(); uir_s.delete();
            for (int i = 0; i <= S; i++) begin udr_s.push_back(1); uir_s.push_back(1); end
            m_init = 1;
        end else if (m_init) begin
            // udr_s[0] is the newest sample; compare samples S-1 and S edges old.
            de = udr_s[S-1] && !udr_s[S];
            ue = uir_s[S-1] && !uir_s[S];
            ire  = ue ? ir_in : m_irq;
            pop  = (mq.size() > 0) && act_ready;
            full = (mq.size() == DEPTH);
            if (pop) void'(mq.pop_front());
            if (de) begin
                m_jdo = sr;
                if (!full || pop) mq.push_back({ire, sr});
                else begin
                    m_ovf = 1;
                    m_drops = clear_ovf ? 1 : (m_drops < 255 ? m_drops + 1 : 255);
                end
            end
            if (clear_ovf && !(de && full && !pop)) begin m_ovf = 0; m_drops = 0; end
            if (ue) m_irq = ir_in;
            udr_s.push_front(vs_udr); void'(udr_s.pop_back());
            uir_s.push_front(vs_uir); void'(uir_s.pop_back());
        end
    end

    // Compare every cycle once the model is initialised.
    always @(negedge clk) begin
        if (m_init) begin
            chk("act_valid",  64'(act_valid),  64'(mq.size() > 0));
            chk("level",      64'(level),      64'(mq.size()));
            chk("act_ir",     64'(act_ir),     mq.size() > 0 ? 64'(mq[0][IRW+SRW-1:SRW]) : 64'd0);
            chk("act_data",   64'(act_data),   mq.size() > 0 ? 64'(mq[0][SRW-1:0]) : 64'd0);
            chk("jdo",        64'(jdo),        64'(m_jdo));
            chk("overflow",   64'(overflow),   64'(m_ovf));
            chk("drop_count", 64'(drop_count), 64'(m_drops));
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic udr_pulse(input logic [SRW-1:0] v);
        sr = v; vs_udr = 1'b1; cyc(S + 1); vs_udr = 1'b0; cyc(S + 1);
    endtask

    task automatic uir_pulse(input logic [IRW-1:0] v);
        ir_in = v; vs_uir = 1'b1; cyc(S + 1); vs_uir = 1'b0; cyc(S + 1);
    endtask

    initial begin
        int first, cnt;
        logic [IRW-1:0] hir;
        logic [SRW-1:0] hdata;

        // reset state
        reset = 1'b1; cyc(3); reset = 1'b0; cyc(2);
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_valid", 64'(act_valid), 64'd0);
        chk("rst_jdo",   64'(jdo), 64'd0);

        // IR pulse then DR pulse with consumer ready
        uir_pulse(2'b01);
        sr = 38'h20_0000_1234; act_ready = 1'b1; vs_udr = 1'b1;
        first = -1; cnt = 0; hir = '0; hdata = '0;
        for (int i = 1; i <= 10; i++) begin
            cyc(1);
            if (i == 4) vs_udr = 1'b0;
            if (act_valid) begin
                if (first < 0) begin first = i; hir = act_ir; hdata = act_data; end
                cnt++;
            end
        end
        chk("t1_latency", 64'(first), 64'd3);
        chk("t1_vcycles", 64'(cnt), 64'd1);
        chk("t1_ir",      64'(hir), 64'h1);
        chk("t1_data",    64'(hdata), 64'h20_0000_1234);
        chk("t1_take",    64'(hdata[SRW-1]), 64'd1);
        chk("t1_jdo",     64'(jdo), 64'h20_0000_1234);

        // simultaneous IR/DR update uses the new IR
        act_ready = 1'b0;
        uir_pulse(2'b00);
        ir_in = 2'b10; sr = 38'h5; vs_uir = 1'b1; vs_udr = 1'b1;
        cyc(4); vs_uir = 1'b0; vs_udr = 1'b0; cyc(4);
        chk("t2_valid", 64'(act_valid), 64'd1);
        chk("t2_ir",    64'(act_ir), 64'h2);
        act_ready = 1'b1; cyc(2); act_ready = 1'b0;

        // fill and overflow
        for (int k = 1; k <= 6; k++) udr_pulse(SRW'(k));
        chk("t3_level", 64'(level), 64'd4);
        chk("t3_ovf",   64'(overflow), 64'd1);
        chk("t3_drops", 64'(drop_count), 64'd2);
        chk("t3_jdo",   64'(jdo), 64'd6);
        act_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            chk("t3_popv", 64'(act_valid), 64'd1);
            chk("t3_popd", 64'(act_data), 64'(k));
            cyc(1);
        end
        chk("t3_empty", 64'(act_valid), 64'd0);
        act_ready = 1'b0;

        // push coinciding with pop at full is accepted
        clear_ovf = 1'b1; cyc(1); clear_ovf = 1'b0;
        for (int k = 11; k <= 14; k++) udr_pulse(SRW'(k));
        sr = 38'd15; vs_udr = 1'b1; cyc(S); act_ready = 1'b1; cyc(1); act_ready = 1'b0;
        chk("t4_level", 64'(level), 64'd4);
        chk("t4_ovf",   64'(overflow), 64'd0);
        chk("t4_head",  64'(act_data), 64'd12);
        vs_udr = 1'b0; cyc(S + 1);
        // one drop, then a drop coinciding with clear
        udr_pulse(38'd16);
        chk("t4_drop1", 64'(drop_count), 64'd1);
        sr = 38'd17; vs_udr = 1'b1; cyc(S); clear_ovf = 1'b1; cyc(1); clear_ovf = 1'b0;
        chk("t4_clr_ovf",   64'(overflow), 64'd1);
        chk("t4_clr_drops", 64'(drop_count), 64'd1);
        vs_udr = 1'b0; cyc(S + 1);

        // reset with a queue and a held strobe
        act_ready = 1'b1; cyc(1); act_ready = 1'b0;
        chk("t5_pre_level", 64'(level), 64'd3);
        vs_udr = 1'b1; cyc(1); reset = 1'b1; cyc(3); reset = 1'b0; cyc(6);
        chk("t5_level", 64'(level), 64'd0);
        chk("t5_valid", 64'(act_valid), 64'd0);
        vs_udr = 1'b0; cyc(4);
        chk("t5_still0", 64'(level), 64'd0);
        sr = 38'd21; vs_udr = 1'b1; cyc(4); vs_udr = 1'b0; cyc(4);
        chk("t5_level1", 64'(level), 64'd1);

        // drop_count saturation
        for (int k = 0; k < 310; k++) udr_pulse(SRW'(k));
        chk("t6_sat", 64'(drop_count), 64'd255);
        chk("t6_ovf", 64'(overflow), 64'd1);

        // random traffic
        for (int c = 0; c < 4000; c++) begin
            cyc(1);
            if ($urandom_range(0, 7) == 0) vs_udr = ~vs_udr;
            if ($urandom_range(0, 11) == 0) vs_uir = ~vs_uir;
            if ($urandom_range(0, 5) == 0) ir_in = IRW'($urandom());
            sr        = SRW'({$urandom(), $urandom()});
            act_ready = ($urandom_range(0, 3) != 0);
            clear_ovf = ($urandom_range(0, 40) == 0);
            reset     = ($urandom_range(0, 600) == 0);
        end
        reset = 1'b0; clear_ovf = 1'b0;
        cyc(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
